// File: rtl/regwr_decode_sb_if.sv
// rtl/regwr_decode_sb_if.sv - issue/writeback bus between the datapath and the write-address decoder
interface regwr_decode_sb_if #(
    parameter int ADDR_W = 5
);
    localparam int NREG = 2 ** ADDR_W;

    logic              en;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_ready;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [NREG-1:0]   wb_dec;
    logic [NREG-1:0]   busy;
    logic [ADDR_W:0]   busy_cnt;
    logic              wb_err;

    modport master (
        output en, issue_valid, issue_addr, wb_valid, wb_addr,
        input  issue_ready, wb_dec, busy, busy_cnt, wb_err
    );

    modport slave (
        input  en, issue_valid, issue_addr, wb_valid, wb_addr,
        output issue_ready, wb_dec, busy, busy_cnt, wb_err
    );
endinterface

// File: rtl/regwr_decode_sb.sv
// rtl/regwr_decode_sb.sv - write-address decoder with busy-bit scoreboard
// Optional macro REGWR_ZERO_REG_EN hardwires register 0 (never busy, never decoded).
module regwr_decode_sb #(
    parameter int ADDR_W  = 5,
    parameter int MAX_OUT = 2 ** ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    regwr_decode_sb_if.slave      bus
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   MAX_OUT_C = MAX_OUT[ADDR_W:0];
    localparam logic [NREG-1:0]   ONE_HOT0  = {{(NREG-1){1'b0}}, 1'b1};

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] r_wb_dec;
    logic [ADDR_W:0] r_busy_cnt;
    logic            r_wb_err;

    logic            w_issue_ready;
    logic            w_set;
    logic            w_wb;
    logic            w_clr;
    logic            w_err;
    logic [NREG-1:0] w_dec;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;

    always_comb begin
        w_issue_ready = bus.en & ~r_busy[bus.issue_addr] & (r_busy_cnt < MAX_OUT_C);
        w_set         = bus.issue_valid & w_issue_ready;
        w_wb          = bus.wb_valid & bus.en;
        // A same-address issue is already blocked by the busy bit, so set and clear never collide.
        w_clr         = w_wb & r_busy[bus.wb_addr];
        w_err         = w_wb & ~r_busy[bus.wb_addr];
        w_dec         = w_wb ? (ONE_HOT0 << bus.wb_addr) : '0;
`ifdef REGWR_ZERO_REG_EN
        if (bus.issue_addr == '0) begin
            w_issue_ready = bus.en;
            w_set         = 1'b0;
        end
        if (bus.wb_addr == '0) begin
            w_err = 1'b0;
            w_dec = '0;
        end
`endif
        w_set_mask = w_set ? (ONE_HOT0 << bus.issue_addr) : '0;
        w_clr_mask = w_clr ? (ONE_HOT0 << bus.wb_addr) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
            r_wb_dec   <= '0;
            r_wb_err   <= 1'b0;
        end else begin
            r_busy     <= (r_busy | w_set_mask) & ~w_clr_mask;
            r_busy_cnt <= r_busy_cnt + {{ADDR_W{1'b0}}, w_set} - {{ADDR_W{1'b0}}, w_clr};
            r_wb_dec   <= w_dec;
            r_wb_err   <= w_err;
        end
    end

    assign bus.issue_ready = w_issue_ready;
    assign bus.busy        = r_busy;
    assign bus.busy_cnt    = r_busy_cnt;
    assign bus.wb_dec      = r_wb_dec;
    assign bus.wb_err      = r_wb_err;
endmodule

// File: tb/tb_regwr_decode_sb.sv
// tb/tb_regwr_decode_sb.sv - directed and randomized checks of regwr_decode_sb against a set-based model
module tb_regwr_decode_sb;
    localparam int ADDR_W  = 5;
    localparam int NREG    = 2 ** ADDR_W;
    localparam int MAX_OUT = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bit   m_busy [NREG];

    regwr_decode_sb_if #(.ADDR_W(ADDR_W)) bus ();

    regwr_decode_sb #(.ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += m_busy[i];
        return n;
    endfunction

    function automatic logic [31:0] m_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit is_zero_reg(input int a);
`ifdef REGWR_ZERO_REG_EN
        return a == 0;
`else
        return 1'b0;
`endif
    endfunction

    // One cycle: drive, check issue_ready before the edge, then check registered state after it.
    task automatic step(input bit e, input bit iv, input int ia, input bit wv, input int wa);
        bit          exp_ready;
        bit          exp_err;
        logic [31:0] exp_dec;
        bus.en          = e;
        bus.issue_valid = iv;
        bus.issue_addr  = ia[ADDR_W-1:0];
        bus.wb_valid    = wv;
        bus.wb_addr     = wa[ADDR_W-1:0];
        #1;
        if (is_zero_reg(ia)) exp_ready = e;
        else exp_ready = e && !m_busy[ia] && (m_count() < MAX_OUT);
        chk("issue_ready", {31'b0, bus.issue_ready}, {31'b0, exp_ready});
        exp_err = 1'b0;
        exp_dec = '0;
        if (wv && e && !is_zero_reg(wa)) begin
            exp_err = !m_busy[wa];
            exp_dec = 32'd1 << wa;
            m_busy[wa] = 1'b0;
        end
        if (iv && exp_ready && !is_zero_reg(ia)) m_busy[ia] = 1'b1;
        @(posedge clk);
        #1;
        chk("busy", bus.busy, m_vec());
        chk("busy_cnt", {26'b0, bus.busy_cnt}, m_count());
        chk("wb_dec", bus.wb_dec, exp_dec);
        chk("wb_err", {31'b0, bus.wb_err}, {31'b0, exp_err});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_addr = '0;
        bus.wb_valid = 1'b0;
        bus.wb_addr = '0;
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", bus.busy, 32'h0);
        chk("reset_cnt", {26'b0, bus.busy_cnt}, 32'h0);
        chk("reset_dec", bus.wb_dec, 32'h0);
        chk("reset_err", {31'b0, bus.wb_err}, 32'h0);
        rst = 1'b0;

        // Decode of a non-busy register flags an error but still decodes.
        step(1, 0, 0, 1, 4);
        chk("dec4_literal", bus.wb_dec, 32'h0000_0010);
        // Reserve and release.
        step(1, 1, 7, 0, 0);
        chk("busy7_literal", bus.busy, 32'h80);
        step(1, 1, 7, 0, 0);
        step(1, 0, 0, 1, 7);
        chk("dec7_literal", bus.wb_dec, 32'h80);
        // Same-cycle collision on register 3.
        step(1, 1, 3, 0, 0);
        step(1, 1, 3, 1, 3);
        step(1, 1, 3, 0, 0);
        chk("busy3_literal", bus.busy, 32'h8);
        step(1, 0, 0, 1, 3);
        // Capacity limit.
        step(1, 1, 1, 0, 0);
        step(1, 1, 2, 0, 0);
        step(1, 1, 5, 0, 0);
        step(1, 1, 5, 1, 1);
        step(1, 1, 5, 0, 0);
        chk("cap_literal", bus.busy, 32'h24);
        // Disabled writeback is ignored.
        step(0, 1, 9, 1, 2);
        // Asynchronous reset between edges.
        rst = 1'b1;
        #1;
        chk("async_busy", bus.busy, 32'h0);
        chk("async_cnt", {26'b0, bus.busy_cnt}, 32'h0);
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Register 0 handling (hardwired only when the macro is defined).
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0);

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 7) != 0), $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regwr_decode_sb.md
Name: regwr_decode_sb

Overview:
- Parametrised successor to the 5-to-32 write-address decoder.
- Decodes an ADDR_W-bit register address into a registered one-hot write-enable vector for the register file.
- Keeps a busy-bit scoreboard, so instructions can only issue a destination that has no write outstanding.
- Sits between the issue stage and the writeback port of the CPU datapath.

Parameters:
- ADDR_W, 5, address width; decoded vector width NREG = 2**ADDR_W.
- MAX_OUT, NREG, maximum number of simultaneously busy registers; issue stalls when the count reaches it.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- en  in  1  global decode enable; when low, no issue is accepted and wb_dec is forced to 0 next cycle.
- issue_valid  in  1  issue stage requests a destination reservation.
- issue_addr  in  ADDR_W  destination register being reserved.
- issue_ready  out  1  reservation accepted this cycle (combinational).
- wb_valid  in  1  writeback of a result this cycle.
- wb_addr  in  ADDR_W  register being written back.
- wb_dec  out  NREG  registered one-hot write enable to the register file.
- busy  out  NREG  scoreboard bit per register.
- busy_cnt  out  ADDR_W+1  number of set busy bits.
- wb_err  out  1  one-cycle pulse: writeback to a non-busy register.

Behaviour:
- Reset (async, rst=1): busy=0, busy_cnt=0, wb_dec=0, wb_err=0. Reset mid-operation discards all reservations immediately, without waiting for a clock edge.
- issue_ready = en & ~busy[issue_addr] & (busy_cnt < MAX_OUT). It is a pure combinational function of current state and inputs, independent of issue_valid.
- Issue fire = issue_valid & issue_ready. On fire, busy[issue_addr] is set at the next edge.
- wb_dec timing: wb_dec is valid one cycle after a writeback.
  - If wb_valid & en, then wb_dec = 1<<wb_addr on the next cycle; otherwise wb_dec = 0.
  - Always exactly zero or one bit set.
- Writeback clear: on wb_valid & en, busy[wb_addr] is cleared at the next edge.
- wb_err: on wb_valid & en with busy[wb_addr]=0, wb_err=1 for exactly one cycle, registered, aligned with wb_dec. The decode still happens.
- Simultaneous issue and writeback:
  - Same address: issue_ready is already 0 because the bit is busy, so the result is clear only. Issue retries next cycle and succeeds then.
  - Different addresses: set and clear both apply in the same cycle.
- busy_cnt update: busy_cnt(next) = busy_cnt + fire − (valid clear of a busy bit). It never wraps, since MAX_OUT ≤ NREG.
  - At busy_cnt == MAX_OUT, issue_ready=0.
  - A simultaneous writeback frees a slot, visible on the following cycle.
- en=0: busy vector and counter hold; issue_ready=0; writebacks ignored (no clear, no err).

Optional Feature:
- Macro: REGWR_ZERO_REG_EN.
- Defined: register 0 is hardwired (MIPS $zero).
  - issue_addr=0 is always ready (subject to en only), never sets busy, and never counts.
  - A writeback to 0 produces wb_dec=0 and no wb_err.
  - busy[0] is constant 0.
- Undefined: register 0 behaves like all others.

Test Plan:
- Reset then decode: rst pulse, en=1, wb_valid=1, wb_addr=4 → next cycle wb_dec=32'h0000_0010 and wb_err=1 (4 not busy); busy stays 0.
- Reserve and release: issue addr 7 → busy=32'h80, busy_cnt=1. A second issue to 7 gives issue_ready=0. wb addr 7 → next cycle busy=0, wb_dec=32'h80, wb_err=0.
- Same-cycle collision: busy[3]=1; issue 3 and wb 3 together → issue_ready=0, busy[3] cleared; the issue retries and is accepted next cycle, giving busy[3]=1.
- Capacity: MAX_OUT=2; issue 1 and 2 → busy_cnt=2 and issue 5 is stalled. wb 1 together with issue 5 → still stalled that cycle, accepted the next; busy_cnt returns to 2.
- Enable and async reset: en=0 with wb 1 → wb_dec=0, busy unchanged. Assert rst between edges with busy_cnt=2 → busy=0 and busy_cnt=0 immediately, before the next clk edge.
- With REGWR_ZERO_REG_EN defined: issue 0 → accepted, busy_cnt stays 0. wb 0 → wb_dec=0, wb_err=0.
